// File: rtl/value_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : value_mux_arbiter
// Purpose  : Arbitrates the two-input value mux feeding the ALU between two
//            operand requesters, captures the winning value into an output
//            register and presents it downstream with valid/ready.
//            Requester 0 has priority; a burst counter bounds the number of
//            consecutive requester-0 grants while requester 1 is waiting.
// Revision : 1.0  initial release
// ============================================================================
module value_mux_arbiter #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  // Counter is wide enough for the full 1..15 burst range.
  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               sel_q, sel_d;
  logic [3:0]         burst_cnt_q, burst_cnt_d;

  logic               can_capture;
  logic               win0;
  logic               win1;

  // Arbitration, capture and next-state computation.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    sel_d       = sel_q;
    burst_cnt_d = burst_cnt_q;

    // The output register is free when empty or being drained this cycle.
    can_capture = (state_q == IDLE) || out_ready;
    // Requester 1 wins when uncontested or when requester 0 has used up its burst.
    win1        = can_capture && req1 && (!req0 || (burst_cnt_q == MAX_CNT));
    win0        = can_capture && !win1 && req0;

    if (win0 || win1) begin
      out_data_d = win1 ? data1 : data0;
      sel_d      = win1;
      state_d    = SEND;
      if (win1) begin
        burst_cnt_d = 4'd0;
      end else if (req1) begin
        burst_cnt_d = (burst_cnt_q == MAX_CNT) ? MAX_CNT : (burst_cnt_q + 4'd1);
      end else begin
        burst_cnt_d = 4'd0;
      end
    end else if ((state_q == SEND) && out_ready) begin
      // Value delivered and nothing new to capture.
      state_d = IDLE;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      sel_q       <= 1'b0;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      sel_q       <= sel_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Acks are suppressed during reset so no value is consumed and then lost.
  assign ack0      = win0 && !reset;
  assign ack1      = win1 && !reset;
  assign sel       = sel_q;
  assign out_valid = (state_q == SEND);
  assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_value_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_value_mux_arbiter
// Purpose  : Self-checking bench for value_mux_arbiter. Expected deliveries
//            ({sel, data}) are queued when a capture is expected and popped
//            when the DUT presents a value that downstream accepts.
// Revision : 1.0  initial release
// ============================================================================
module tb_value_mux_arbiter;

  localparam int W = 5;

  logic         clk;
  logic         reset;
  logic         req0;
  logic [W-1:0] data0;
  logic         req1;
  logic [W-1:0] data1;
  logic         ack0;
  logic         ack1;
  logic         sel;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  int total;
  int bad;
  logic [W:0] exp_q[$];

  value_mux_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .data0     (data0),
    .req1      (req1),
    .data1     (data1),
    .ack0      (ack0),
    .ack1      (ack1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock: capture edge, then settle at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [W:0] got;
    @(negedge clk);
    reset = 1'b1; req0 = 1'b1; data0 = 5'h1F; out_ready = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      total++;
      if (ack0 !== 1'b0) begin
        bad++; $display("FAIL reset_ack0 cyc%0d got=%b exp=0", c, ack0);
      end
      step();
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++;
    if (out_data !== 5'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
    total++;
    if (sel !== 1'b0) begin bad++; $display("FAIL reset_sel got=%b exp=0", sel); end
    got = {sel, out_data};
    reset = 1'b0; req0 = 1'b0;
  endtask

  task automatic test_single();
    logic [W:0] e;
    req0 = 1'b1; data0 = 5'h0A; out_ready = 1'b1;
    #1;
    total++;
    if (ack0 !== 1'b1) begin bad++; $display("FAIL single_ack0 got=%b exp=1", ack0); end
    exp_q.push_back({1'b0, 5'h0A});
    step();
    req0 = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL single_valid got=%b exp=1", out_valid);
    end else begin
      e = exp_q.pop_front();
      total++;
      if ({sel, out_data} !== e) begin
        bad++; $display("FAIL single_data got=%h exp=%h", {sel, out_data}, e);
      end
    end
    total++;
    if (ack0 !== 1'b0) begin bad++; $display("FAIL single_noack got=%b exp=0", ack0); end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [W:0] e;
    req1 = 1'b1; data1 = 5'h15; req0 = 1'b0; out_ready = 1'b0;
    #1;
    total++;
    if (ack1 !== 1'b1) begin bad++; $display("FAIL bp_ack1 got=%b exp=1", ack1); end
    exp_q.push_back({1'b1, 5'h15});
    step();
    req1 = 1'b0; req0 = 1'b1; data0 = 5'h0C;
    #1;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (ack0 !== 1'b0) begin bad++; $display("FAIL bp_hold_ack0 cyc%0d got=%b exp=0", c, ack0); end
      total++;
      if ({out_valid, sel, out_data} !== {1'b1, 1'b1, 5'h15}) begin
        bad++; $display("FAIL bp_hold cyc%0d got=%h exp=%h", c, {out_valid, sel, out_data},
                        {1'b1, 1'b1, 5'h15});
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (ack0 !== 1'b1) begin bad++; $display("FAIL bp_release_ack0 got=%b exp=1", ack0); end
    if (out_valid && out_ready) begin
      e = exp_q.pop_front();
      total++;
      if ({sel, out_data} !== e) begin
        bad++; $display("FAIL bp_deliver1 got=%h exp=%h", {sel, out_data}, e);
      end
    end
    exp_q.push_back({1'b0, 5'h0C});
    step();
    req0 = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_deliver2_valid got=%b exp=1", out_valid);
    end else begin
      e = exp_q.pop_front();
      total++;
      if ({sel, out_data} !== e) begin
        bad++; $display("FAIL bp_deliver2 got=%h exp=%h", {sel, out_data}, e);
      end
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b exp=0", out_valid); end
  endtask

  // Continuous contention: requester 1 must win every fifth grant.
  task automatic test_starvation();
    logic [W:0] e;
    logic       w;
    req0 = 1'b1; req1 = 1'b1; data0 = 5'h01; data1 = 5'h11; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      w = ((i % 5) == 4);
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL starve_underflow i=%0d got=%h", i, {sel, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({sel, out_data} !== e) begin
            bad++; $display("FAIL starve_data i=%0d got=%h exp=%h", i, {sel, out_data}, e);
          end
        end
      end
      total++;
      if ({ack1, ack0} !== {w, ~w}) begin
        bad++; $display("FAIL starve_grant i=%0d got=%b exp=%b", i, {ack1, ack0}, {w, ~w});
      end
      exp_q.push_back(w ? {1'b1, data1} : {1'b0, data0});
      step();
      if (w) data1 = data1 + 5'd1;
      else   data0 = data0 + 5'd1;
      #1;
    end
    req0 = 1'b0; req1 = 1'b0;
    #1;
    total++;
    if (exp_q.size() != 1 || !out_valid) begin
      bad++; $display("FAIL starve_tail got=%0d/%b exp=1/1", exp_q.size(), out_valid);
    end else begin
      e = exp_q.pop_front();
      total++;
      if ({sel, out_data} !== e) begin
        bad++; $display("FAIL starve_last got=%h exp=%h", {sel, out_data}, e);
      end
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL starve_idle got=%b exp=0", out_valid); end
  endtask

  // A requester-0 grant with requester 1 absent restarts the burst budget.
  task automatic test_burst_reset();
    logic [W:0] e;
    logic [8:0] r1_sched;
    logic [8:0] win_sched;
    r1_sched  = 9'b1_1111_0111;   // bit i = req1 in grant slot i
    win_sched = 9'b1_0000_0000;   // bit i = expected winner in slot i
    req0 = 1'b1; data0 = 5'h03; data1 = 5'h1C; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req1 = r1_sched[i];
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL burst_underflow i=%0d got=%h", i, {sel, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({sel, out_data} !== e) begin
            bad++; $display("FAIL burst_data i=%0d got=%h exp=%h", i, {sel, out_data}, e);
          end
        end
      end
      total++;
      if ({ack1, ack0} !== {win_sched[i], ~win_sched[i]}) begin
        bad++; $display("FAIL burst_grant i=%0d got=%b exp=%b", i, {ack1, ack0},
                        {win_sched[i], ~win_sched[i]});
      end
      exp_q.push_back(win_sched[i] ? {1'b1, data1} : {1'b0, data0});
      step();
      if (win_sched[i]) data1 = data1 + 5'd1;
      else              data0 = data0 + 5'd1;
    end
    req0 = 1'b0; req1 = 1'b0;
    #1;
    total++;
    if (exp_q.size() != 1 || !out_valid) begin
      bad++; $display("FAIL burst_tail got=%0d/%b exp=1/1", exp_q.size(), out_valid);
    end else begin
      e = exp_q.pop_front();
      total++;
      if ({sel, out_data} !== e) begin
        bad++; $display("FAIL burst_last got=%h exp=%h", {sel, out_data}, e);
      end
    end
    step();
  endtask

  task automatic test_reset_mid_send();
    req0 = 1'b1; data0 = 5'h07; out_ready = 1'b0;
    #1;
    total++;
    if (ack0 !== 1'b1) begin bad++; $display("FAIL midrst_ack0 got=%b exp=1", ack0); end
    step();
    req0 = 1'b0;
    #1;
    total++;
    if ({out_valid, out_data} !== {1'b1, 5'h07}) begin
      bad++; $display("FAIL midrst_pre got=%h exp=%h", {out_valid, out_data}, {1'b1, 5'h07});
    end
    reset = 1'b1; req0 = 1'b1; data0 = 5'h09;
    #1;
    total++;
    if (ack0 !== 1'b0) begin bad++; $display("FAIL midrst_ack_in_reset got=%b exp=0", ack0); end
    step();
    total++;
    if ({out_valid, sel, out_data} !== {1'b0, 1'b0, 5'h00}) begin
      bad++; $display("FAIL midrst_post got=%h exp=00", {out_valid, sel, out_data});
    end
    reset = 1'b0; req0 = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%b exp=0", out_valid); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    data0 = '0; data1 = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_starvation();
    test_burst_reset();
    test_reset_mid_send();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL queue_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/value_mux_arbiter.md
Name: value_mux_arbiter

Overview:
- Shares the 5-bit two-input value mux between two requesters (operand sources) feeding the ALU.
- Picks a winner per transfer, drives the mux select, and captures the winning value into an output register.
- Presents the captured value downstream with a valid/ready handshake.
- Requester 0 has priority; a burst limit guarantees requester 1 is not starved.

Parameters:
- WIDTH, 5, data width of each requester value and of out_data.
- MAX_BURST, 4, max consecutive grants to requester 0 while req1 is pending; range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 has a value; held with data0 stable until ack0.
- data0  input  WIDTH  requester 0 value (mux Input0).
- req1  input  1  requester 1 has a value; held with data1 stable until ack1.
- data1  input  WIDTH  requester 1 value (mux Input1).
- ack0  output  1  combinational; high in the cycle data0 is captured.
- ack1  output  1  combinational; high in the cycle data1 is captured.
- sel  output  1  registered mux select; equals the last winner.
- out_valid  output  1  registered; out_data holds an undelivered value.
- out_data  output  WIDTH  registered captured value.
- out_ready  input  1  downstream accepts out_data when out_valid && out_ready.

Behaviour:
- Reset values (synchronous reset, active-high): state=IDLE, out_valid=0, out_data=0, sel=0, burst_cnt=0. ack0/ack1 forced 0 while reset is high.
- Reset mid-operation drops any undelivered out_data. A requester whose value was already acked is not re-served.
- States:
  - IDLE: out_valid=0.
  - SEND: out_valid=1.
- can_capture = (state==IDLE) || (state==SEND && out_ready).
- Winner when can_capture:
  - req1 && (!req0 || burst_cnt==MAX_BURST) -> winner 1.
  - Otherwise req0 -> winner 0.
  - Otherwise no winner.
- Capture cycle, when a winner exists:
  - ack[winner]=1 combinationally.
  - At the clock edge: out_data <= data[winner], sel <= winner, out_valid <= 1, state <= SEND.
  - Latency from req to out_valid is 1 cycle.
- SEND && out_ready && no winner -> state <= IDLE, out_valid <= 0.
- SEND && !out_ready: hold out_data, sel and out_valid. No ack; no capture.
- Back-to-back: SEND && out_ready && winner -> deliver and capture in the same cycle. out_valid stays 1, so throughput is 1 value/cycle.
- burst_cnt update, on capture only:
  - Winner 0 with req1 high -> burst_cnt+1, saturating at MAX_BURST.
  - Winner 0 with req1 low -> 0.
  - Winner 1 -> 0.
- ack is one cycle per capture. A requester keeping req high after ack is treated as a new value.
- Simultaneous req0, req1 and out_ready in SEND: the arbitration rule above applies; delivery of the old value and capture of the new one happen on the same edge.
- sel never changes except on a capture edge or reset.

Test Plan:
- Reset: hold reset 2 cycles with req0=1, data0=5'h1F -> ack0=0 during reset; out_valid=0, out_data=0, sel=0 after reset.
- Single transfer: req0=1, data0=5'h0A, out_ready=1 -> ack0 in cycle 0; out_valid=1, out_data=0x0A, sel=0 in cycle 1; req0 drops -> out_valid=0 in cycle 2.
- Backpressure: capture data1=5'h15 with out_ready=0 for 3 cycles, req0 asserted -> out_data stays 0x15, sel=1, no ack0 until out_ready=1. Then ack0 and the next out_data=data0.
- Starvation guard (MAX_BURST=4): req0 and req1 high continuously, out_ready=1 -> grant sequence 0,0,0,0,1,0,0,0,0,1,...
- Burst reset: after 3 grants to 0, drop req1 for one capture, then raise it -> 4 more grants to 0 before the next grant to 1.
- Reset mid-SEND: out_valid=1, out_data=0x07, out_ready=0, assert reset -> next cycle out_valid=0, out_data=0, state IDLE.
